// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and forwarding controller for an in-order RV32I pipeline
//   (IF, ID, EX, MEM .. WB). It tracks its own scoreboard of the
//   instructions in EX and the FWD_STAGES result-holding stages after it.
//   From that scoreboard it derives the load-use stall, the
//   branch-redirect flush and a forwarding select for every EX source
//   operand.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   id_valid     ID holds a real instruction
//   id_rs        ID source register numbers, source j at [j*AW +: AW]
//   id_rs_en     per-source read enable
//   id_rd        ID destination register
//   id_regwrite  ID instruction writes rd
//   id_memread   ID instruction is a load
//   ex_redirect  EX resolved a taken branch/jump this cycle
//   cnt_clr      synchronous clear of both performance counters
//   stall        hold PC and IF/ID, insert a bubble into EX
//   flush        clear IF/ID, kill the ID instruction
//   ex_valid     EX holds a real instruction
//   ex_fwd_sel   per EX source: 0 = regfile, s = forward from stage s
//   stall_cnt    saturating count of stall cycles
//   flush_cnt    saturating count of flush cycles
module pipe_hazard_ctrl #(
    parameter int AW         = 5,
    parameter int NSRC       = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    localparam int SELW      = $clog2(FWD_STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_rs,
    input  logic [NSRC-1:0]      id_rs_en,
    input  logic [AW-1:0]        id_rd,
    input  logic                 id_regwrite,
    input  logic                 id_memread,
    input  logic                 ex_redirect,
    input  logic                 cnt_clr,
    output logic                 stall,
    output logic                 flush,
    output logic                 ex_valid,
    output logic [NSRC*SELW-1:0] ex_fwd_sel,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Scoreboard: index 0 is EX, index s is s stages after EX.
    logic [FWD_STAGES:0] sb_valid;
    logic [FWD_STAGES:0] sb_regwrite;
    logic [FWD_STAGES:0] sb_memread;
    logic [AW-1:0]       sb_rd [0:FWD_STAGES];
    // Source operands are only needed while the instruction sits in EX.
    logic [NSRC*AW-1:0]  ex_rs;
    logic [NSRC-1:0]     ex_rs_en;

    logic [FWD_STAGES:0] prod;
    logic                load_hazard;

    always_comb begin
        prod = '0;
        for (int s = 0; s <= FWD_STAGES; s++) begin
            prod[s] = sb_valid[s] & sb_regwrite[s] & (sb_rd[s] != '0);
        end
    end

    // A load younger than LOAD_LAT stages cannot supply its data in time
    // for an instruction that would enter EX on the next edge.
    always_comb begin
        load_hazard = 1'b0;
        for (int s = 0; s < LOAD_LAT; s++) begin
            for (int j = 0; j < NSRC; j++) begin
                if (prod[s] && sb_memread[s] && id_rs_en[j] &&
                    (id_rs[j*AW +: AW] == sb_rd[s])) begin
                    load_hazard = 1'b1;
                end
            end
        end
    end

    assign flush    = ex_redirect & sb_valid[0];
    assign stall    = ~flush & id_valid & load_hazard;
    assign ex_valid = sb_valid[0];

    // Walk from the oldest stage towards EX so the nearest match wins.
    always_comb begin
        ex_fwd_sel = '0;
        for (int j = 0; j < NSRC; j++) begin
            for (int s = FWD_STAGES; s >= 1; s--) begin
                if (sb_valid[0] && ex_rs_en[j] && prod[s] &&
                    (sb_rd[s] == ex_rs[j*AW +: AW]) &&
                    !(sb_memread[s] && (s <= LOAD_LAT))) begin
                    ex_fwd_sel[j*SELW +: SELW] = SELW'(s);
                end
            end
        end
    end

    // ---- stage boundary: ID -> EX -> MEM .. WB (control) ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_valid <= '0;
        end else begin
            sb_valid <= {sb_valid[FWD_STAGES-1:0], id_valid & ~(stall | flush)};
        end
    end

    // ---- stage boundary: ID -> EX -> MEM .. WB (data, qualified by valid) ----
    always_ff @(posedge clk) begin
        sb_regwrite <= {sb_regwrite[FWD_STAGES-1:0], id_regwrite};
        sb_memread  <= {sb_memread[FWD_STAGES-1:0], id_memread};
        sb_rd[0]    <= id_rd;
        for (int s = 1; s <= FWD_STAGES; s++) begin
            sb_rd[s] <= sb_rd[s-1];
        end
        ex_rs    <= id_rs;
        ex_rs_en <= id_rs_en;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall) stall_cnt <= sat_inc(stall_cnt);
            if (flush) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one default instance (2 forwarding stages,
// load latency 1, 16-bit counters) and one with 3 forwarding stages,
// load latency 2 and 4-bit counters, both driven by the same stimulus.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [9:0] id_rs;
    logic [1:0] id_rs_en;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       ex_redirect;
    logic       cnt_clr;

    logic        a_stall, a_flush, a_exv;
    logic [3:0]  a_sel;
    logic [15:0] a_sc, a_fc;
    logic        b_stall, b_flush, b_exv;
    logic [3:0]  b_sel;
    logic [3:0]  b_sc, b_fc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_en(id_rs_en), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .ex_redirect(ex_redirect), .cnt_clr(cnt_clr),
        .stall(a_stall), .flush(a_flush), .ex_valid(a_exv),
        .ex_fwd_sel(a_sel), .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    pipe_hazard_ctrl #(.FWD_STAGES(3), .LOAD_LAT(2), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_en(id_rs_en), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .ex_redirect(ex_redirect), .cnt_clr(cnt_clr),
        .stall(b_stall), .flush(b_flush), .ex_valid(b_exv),
        .ex_fwd_sel(b_sel), .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: for each instance, the instruction history of the last few
    // cycles (hist[k][a] = what entered EX a cycles ago, a=0 is EX now).
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic [9:0] rs;
        logic [1:0] en;
    } ins_t;

    ins_t hist [2][4];
    int   fs   [2] = '{2, 3};
    int   ll   [2] = '{1, 2};
    int   cmax [2] = '{65535, 15};
    int   sc   [2];
    int   fc   [2];

    function automatic bit writes_reg(input ins_t i);
        return i.v && i.rw && (i.rd != 5'd0);
    endfunction

    function automatic bit exp_flush(input int k);
        return ex_redirect && hist[k][0].v;
    endfunction

    // A load issued fewer than LOAD_LAT cycles ago whose rd is read by ID.
    function automatic bit exp_stall(input int k);
        if (exp_flush(k) || !id_valid) return 1'b0;
        for (int a = 0; a < ll[k]; a++)
            for (int j = 0; j < 2; j++)
                if (writes_reg(hist[k][a]) && hist[k][a].mr && id_rs_en[j] &&
                    id_rs[j*5 +: 5] == hist[k][a].rd)
                    return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_sel(input int k, input int j);
        if (!(hist[k][0].v && hist[k][0].en[j])) return 0;
        for (int a = 1; a <= fs[k]; a++)
            if (writes_reg(hist[k][a]) && hist[k][a].rd == hist[k][0].rs[j*5 +: 5] &&
                !(hist[k][a].mr && a <= ll[k]))
                return a;
        return 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 4; a++) hist[k][a] = '0;
            sc[k] = 0;
            fc[k] = 0;
        end
    endtask

    task automatic model_step();
        bit st, fl;
        for (int k = 0; k < 2; k++) begin
            st = exp_stall(k);
            fl = exp_flush(k);
            for (int a = 3; a >= 1; a--) hist[k][a] = hist[k][a-1];
            hist[k][0]    = '0;
            if (!(st || fl)) begin
                hist[k][0].v  = id_valid;
                hist[k][0].rd = id_rd;
                hist[k][0].rw = id_regwrite;
                hist[k][0].mr = id_memread;
                hist[k][0].rs = id_rs;
                hist[k][0].en = id_rs_en;
            end
            if (cnt_clr) begin
                sc[k] = 0;
                fc[k] = 0;
            end else begin
                if (st && sc[k] < cmax[k]) sc[k]++;
                if (fl && fc[k] < cmax[k]) fc[k]++;
            end
        end
    endtask

    initial model_clear();

    always begin
        @(negedge clk);
        #4;
        if (!reset) model_clear();
        chk("a_stall", a_stall, exp_stall(0));
        chk("a_flush", a_flush, exp_flush(0));
        chk("a_exv",   a_exv,   hist[0][0].v);
        chk("a_sel0",  a_sel[1:0], exp_sel(0, 0));
        chk("a_sel1",  a_sel[3:2], exp_sel(0, 1));
        chk("a_scnt",  a_sc, sc[0]);
        chk("a_fcnt",  a_fc, fc[0]);
        chk("b_stall", b_stall, exp_stall(1));
        chk("b_flush", b_flush, exp_flush(1));
        chk("b_exv",   b_exv,   hist[1][0].v);
        chk("b_sel0",  b_sel[1:0], exp_sel(1, 0));
        chk("b_sel1",  b_sel[3:2], exp_sel(1, 1));
        chk("b_scnt",  b_sc, sc[1]);
        chk("b_fcnt",  b_fc, fc[1]);
        if (reset) model_step();
    end

    task automatic cyc(input logic v, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [1:0] en, input logic redir, input logic clr);
        @(negedge clk);
        id_valid    = v;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        id_rs       = {r2, r1};
        id_rs_en    = en;
        ex_redirect = redir;
        cnt_clr     = clr;
    endtask

    task automatic nop(input logic redir, input logic clr);
        cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, redir, clr);
    endtask

    initial begin
        reset = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rs_en = '0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; ex_redirect = 1'b0; cnt_clr = 1'b0;
        #2;
        chk("rst_stall", a_stall, 0);
        chk("rst_exv", a_exv, 0);
        chk("rst_sel", a_sel, 0);
        chk("rst_cnt", a_sc, 0);
        @(negedge clk);
        reset = 1'b1;

        // ADD x5; ADD x6<-x5; ADD x8; ADD x9<-x6
        cyc(1, 5, 1, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 6, 1, 0, 5, 0, 2'b01, 0, 0);
        cyc(1, 8, 1, 0, 0, 0, 2'b00, 0, 0);
        #3 chk("t1_fwd1", a_sel[1:0], 1);
        chk("t1_nostall", a_stall, 0);
        cyc(1, 9, 1, 0, 6, 0, 2'b01, 0, 0);
        nop(0, 0);
        #3 chk("t1_fwd2", a_sel[1:0], 2);

        // Two producers of x5 in flight
        cyc(1, 5, 1, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 5, 1, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 11, 1, 0, 5, 0, 2'b01, 0, 0);
        nop(0, 0);
        #3 chk("t2_nearest", a_sel[1:0], 1);

        // LW x7; ADD rs2=x7 (held in ID while stalled)
        cyc(1, 7, 1, 1, 0, 0, 2'b00, 0, 0);
        cyc(1, 12, 1, 0, 0, 7, 2'b10, 0, 0);
        #3 chk("t3_stall", a_stall, 1);
        cyc(1, 12, 1, 0, 0, 7, 2'b10, 0, 0);
        #3 chk("t3_bubble", a_exv, 0);
        chk("t3_stall_end", a_stall, 0);
        nop(0, 0);
        #3 chk("t3_fwd_load", a_sel[3:2], 2);
        chk("t3_cnt", a_sc, 1);

        // x0 is never a hazard source
        cyc(1, 0, 1, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 0, 1, 1, 0, 0, 2'b00, 0, 0);
        cyc(1, 13, 1, 0, 0, 0, 2'b11, 0, 0);
        #3 chk("t4_nostall", a_stall, 0);
        nop(0, 0);
        #3 chk("t4_nofwd", a_sel, 0);

        // Redirect while a load-use is pending
        cyc(1, 7, 1, 1, 0, 0, 2'b00, 0, 0);
        cyc(1, 14, 1, 0, 7, 0, 2'b01, 1, 0);
        #3 chk("t5_flush", a_flush, 1);
        chk("t5_nostall", a_stall, 0);
        nop(1, 0);
        #3 chk("t5_noflush_inv", a_flush, 0);
        chk("t5_bubble", a_exv, 0);
        chk("t5_fcnt", a_fc, 1);
        nop(0, 1);
        nop(0, 0);
        #3 chk("clr_scnt", a_sc, 0);
        chk("clr_fcnt", a_fc, 0);

        // Deeper pipeline, load latency 2
        for (int i = 0; i < 4; i++) nop(0, 0);
        cyc(1, 9, 1, 1, 0, 0, 2'b00, 0, 0);
        cyc(1, 15, 1, 0, 9, 0, 2'b01, 0, 0);
        #3 chk("t6_stall1", b_stall, 1);
        cyc(1, 15, 1, 0, 9, 0, 2'b01, 0, 0);
        #3 chk("t6_stall2", b_stall, 1);
        cyc(1, 15, 1, 0, 9, 0, 2'b01, 0, 0);
        #3 chk("t6_stall_end", b_stall, 0);
        nop(0, 0);
        #3 chk("t6_fwd3", b_sel[1:0], 3);
        chk("t6_cnt", b_sc, 2);

        cyc(1, 9, 1, 1, 0, 0, 2'b00, 0, 0);
        cyc(1, 16, 1, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 17, 1, 0, 9, 0, 2'b01, 0, 0);
        #3 chk("t6i_stall", b_stall, 1);
        cyc(1, 17, 1, 0, 9, 0, 2'b01, 0, 0);
        #3 chk("t6i_stall_end", b_stall, 0);

        // 20 stall cycles on a 4-bit counter
        nop(0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 9, 1, 1, 0, 0, 2'b00, 0, 0);
            cyc(1, 18, 1, 0, 9, 0, 2'b01, 0, 0);
            cyc(1, 18, 1, 0, 9, 0, 2'b01, 0, 0);
        end
        nop(0, 0);
        #3 chk("t6_sat", b_sc, 15);

        // Reset asserted in the middle of a stall
        cyc(1, 9, 1, 1, 0, 0, 2'b00, 0, 0);
        cyc(1, 19, 1, 0, 9, 0, 2'b01, 0, 0);
        #2 chk("t6r_stall_before", b_stall, 1);
        reset = 1'b0;
        #1 chk("t6r_stall", b_stall, 0);
        chk("t6r_exv", b_exv, 0);
        chk("t6r_sel", b_sel, 0);
        chk("t6r_cnt", b_sc, 0);
        @(negedge clk);
        reset = 1'b1;
        nop(0, 0);
        nop(0, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
